uart_cmd_ctrl: RTL and testbench

- Command-framing controller that sequences the UART receive path.
- Consumes bytes from the UART receiver (byte plus byte-ready flag) and parses packets of the form SYNC, ADDR, LEN, payload, CHK.
- Buffers the payload and releases it as register-write strobes only after the checksum passes.
- Sits between UART_RX and the PWM/config register bank; reports framing errors to the host-side status logic.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_buf.sv | 34 +++
 rtl/uart_cmd_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-framing controller.
//   state_e        : framing FSM states
//   ERR_*          : error codes reported on err_code
//   SYNC_BYTE_DEF  : default packet start marker
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_DRAIN   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: DEPTH x 8 register file, synchronous write, combinational read.
//   clk      : system clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write byte
//   raddr_i  : read index
//   rdata_o  : byte at raddr_i (0 when the index is outside the buffer)
module uart_cmd_buf
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem_q [DEPTH];

  // Contents need no reset: every entry read in a drain was written by that packet.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < 8'(DEPTH))) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i < 8'(DEPTH)) ? mem_q[raddr_i[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command-framing controller: parses SYNC, ADDR, LEN, payload, CHK,
// buffers the payload and replays it as register writes once the XOR
// checksum matches.
//   clk, RSTn          : system clock, async active-low reset
//   rx_data, rx_irq    : received byte and byte-ready flag (rising edge = byte)
//   wr_en/addr/data    : one-cycle register write strobe
//   pkt_ok, pkt_err    : one-cycle packet status pulses
//   err_code           : last error code, held until the next error
//   busy               : FSM is not idle
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for SYNC_BYTE, other bytes dropped
// ST_ADDR    | waiting for base address byte
// ST_LEN     | waiting for payload length byte
// ST_PAYLOAD | storing payload bytes into the buffer
// ST_CHK     | waiting for checksum byte
// ST_DRAIN   | one register write per cycle, then pkt_ok
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic [7:0] rx_data,
  input  logic       rx_irq,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned   TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic          irq_q;
  logic [7:0]    base_q, base_d, len_q, len_d, chk_q, chk_d, idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pend_vld_q, pend_vld_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic          wr_en_q, wr_en_d, pkt_ok_q, pkt_ok_d, pkt_err_q, pkt_err_d;
  logic [7:0]    wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          ev, use_pend, in_vld, active, tmo, buf_we;
  logic [7:0]    in_byte, buf_rdata;

  assign ev = rx_irq & ~irq_q;

  uart_cmd_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (in_byte),
    .raddr_i (idx_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    // A byte parked during the drain is replayed as the first IDLE event.
    use_pend    = (state_q == ST_IDLE) && pend_vld_q;
    in_vld      = ev | use_pend;
    in_byte     = use_pend ? pend_byte_q : rx_data;
    active      = (state_q inside {ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK});
    tmo         = active && !in_vld && (tmr_q == '0);

    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    pend_vld_d  = pend_vld_q;
    pend_byte_d = pend_byte_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = 8'h00;
    wr_data_d   = 8'h00;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    // A byte event on the same cycle as expiry wins because tmo excludes in_vld.
    if (in_vld) tmr_d = TMR_LOAD;
    else if (active && !tmo) tmr_d = tmr_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (use_pend) begin
          pend_vld_d = ev;
          if (ev) pend_byte_d = rx_data;
        end
        if (in_vld && (in_byte == SYNC_BYTE)) state_d = ST_ADDR;
      end
      ST_ADDR: if (in_vld) begin
        base_d  = in_byte;
        chk_d   = in_byte;
        state_d = ST_LEN;
      end
      ST_LEN: if (in_vld) begin
        if ((in_byte == 8'h00) || (in_byte > 8'(MAX_LEN))) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_LEN;
          state_d    = ST_IDLE;
        end else begin
          len_d   = in_byte;
          chk_d   = chk_q ^ in_byte;
          idx_d   = 8'h00;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (in_vld) begin
        buf_we = 1'b1;
        chk_d  = chk_q ^ in_byte;
        idx_d  = idx_q + 8'd1;
        if (idx_q + 8'd1 == len_q) state_d = ST_CHK;
      end
      ST_CHK: if (in_vld) begin
        if (in_byte == chk_q) begin
          idx_d   = 8'h00;
          state_d = ST_DRAIN;
        end else begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_CHK;
          state_d    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (ev) begin
          pend_vld_d  = 1'b1;
          pend_byte_d = rx_data;
        end
        // idx == len is the extra cycle that carries pkt_ok after the last write.
        if (idx_q == len_q) begin
          pkt_ok_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + idx_q;
          wr_data_d = buf_rdata;
          idx_d     = idx_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo) begin
      pkt_err_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      irq_q       <= 1'b0;
      base_q      <= 8'h00;
      len_q       <= 8'h00;
      chk_q       <= 8'h00;
      idx_q       <= 8'h00;
      tmr_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_byte_q <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      irq_q       <= rx_irq;
      base_q      <= base_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      pend_vld_q  <= pend_vld_d;
      pend_byte_q <= pend_byte_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign pkt_ok   = pkt_ok_q;
  assign pkt_err  = pkt_err_q;
  assign err_code = err_code_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a packet-level reference model pushes
// expected writes / pkt_ok / pkt_err records; a monitor pops and compares.
module tb_uart_cmd_ctrl;

  localparam int MAXL = 16;
  localparam int TMO  = 300;

  logic       clk = 1'b0;
  logic       RSTn;
  logic [7:0] rx_data;
  logic       rx_irq;
  logic       wr_en, pkt_ok, pkt_err, busy;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;

  uart_cmd_ctrl #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_irq(rx_irq),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;  // 0 write, 1 ok, 2 error
    logic [7:0] a;     // address or error code
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  logic [1:0] last_err;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: accumulate packet bytes, decide on the whole packet.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] x;
    int n;
    if (cur.size() == 0) begin
      if (b == 8'hA5) cur.push_back(b);
      return;
    end
    cur.push_back(b);
    n = cur.size();
    if (n == 3 && (b == 0 || b > MAXL)) begin
      exp_q.push_back('{2'd2, 8'd1, 8'd0});
      last_err = 2'd1;
      cur.delete();
    end else if (n > 3 && n == 4 + int'(cur[2])) begin
      x = 8'h00;
      for (int i = 1; i < n - 1; i++) x ^= cur[i];
      if (x == b) begin
        for (int i = 0; i < int'(cur[2]); i++)
          exp_q.push_back('{2'd0, 8'(cur[1] + 8'(i)), cur[3+i]});
        exp_q.push_back('{2'd1, 8'd0, 8'd0});
      end else begin
        exp_q.push_back('{2'd2, 8'd2, 8'd0});
        last_err = 2'd2;
      end
      cur.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    model_byte(b);
    rx_data = b;
    rx_irq  = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_irq = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  logic prev_wr;
  initial begin
    exp_t e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!RSTn) begin
        prev_wr = 1'b0;
        continue;
      end
      if (pkt_ok && pkt_err) chk("ok_err_exclusive", 1, 0);
      if (wr_en || pkt_ok || pkt_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {29'd0, wr_en, pkt_ok, pkt_err}, 0);
        end else begin
          e = exp_q.pop_front();
          if (wr_en) begin
            chk("write_kind", e.kind, 0);
            chk("wr_addr", wr_addr, e.a);
            chk("wr_data", wr_data, e.d);
          end else if (pkt_ok) begin
            chk("ok_kind", e.kind, 1);
            chk("ok_after_last_write", prev_wr, 1);
          end else begin
            chk("err_kind", e.kind, 2);
            chk("err_code", err_code, e.a);
          end
        end
      end
      prev_wr = wr_en;
    end
  end

  initial begin
    logic [7:0] x, b, len, addr;
    int cnt;
    bit found;
    RSTn = 1'b0; rx_irq = 1'b0; rx_data = 8'h00; last_err = 2'd0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {11'd0, wr_en, wr_addr, wr_data, pkt_ok, pkt_err, err_code, busy}, 0);
    RSTn = 1'b1;
    idle(2);

    // Good packet with first-write latency check on the CHK byte.
    send_byte(8'hA5, 1, 1); send_byte(8'h10, 1, 1); send_byte(8'h02, 1, 1);
    send_byte(8'h11, 1, 1); send_byte(8'h22, 1, 1);
    model_byte(8'h21);
    rx_data = 8'h21; rx_irq = 1'b1;
    @(negedge clk) chk("lat_cycle0", wr_en, 0);
    @(negedge clk) chk("lat_cycle1", wr_en, 0);
    @(negedge clk) chk("lat_cycle2", wr_en, 1);
    @(posedge clk); #1 rx_irq = 1'b0;
    idle(10);
    chk("good_err_code", err_code, 0);

    // Address wrap with maximum length.
    send_byte(8'hA5, 1, 2); send_byte(8'hFE, 1, 2); send_byte(8'(MAXL), 1, 2);
    x = 8'hFE ^ 8'(MAXL);
    for (int i = 0; i < MAXL; i++) begin send_byte(8'(i), 1, 1); x ^= 8'(i); end
    send_byte(x, 1, 1);
    idle(30);

    // Bad LEN (0 and MAX_LEN+1), then a good packet.
    send_byte(8'hA5, 1, 1); send_byte(8'h10, 1, 1); send_byte(8'h00, 1, 4);
    send_byte(8'hA5, 1, 1); send_byte(8'h10, 1, 1); send_byte(8'(MAXL + 1), 1, 4);
    chk("badlen_err_code", err_code, 1);
    chk("badlen_idle", busy, 0);
    send_byte(8'hA5, 1, 1); send_byte(8'h40, 1, 1); send_byte(8'h01, 1, 1);
    send_byte(8'h77, 1, 1); send_byte(8'h40 ^ 8'h01 ^ 8'h77, 1, 1);
    idle(10);

    // Bad checksum.
    send_byte(8'hA5, 1, 1); send_byte(8'h10, 1, 1); send_byte(8'h01, 1, 1);
    send_byte(8'h55, 1, 1); send_byte(8'h00, 1, 3);
    chk("badchk_err_code", err_code, 2);
    chk("badchk_idle", busy, 0);

    // Stray byte in IDLE.
    send_byte(8'h3C, 1, 3);
    chk("stray_idle", busy, 0);

    // Timeout after ADDR.
    send_byte(8'hA5, 1, 1);
    send_byte(8'h10, 1, 0);
    cur.delete();
    exp_q.push_back('{2'd2, 8'd3, 8'd0});
    last_err = 2'd3;
    found = 1'b0; cnt = 0;
    while (!found && cnt < TMO + 20) begin
      @(negedge clk); cnt++;
      if (pkt_err) found = 1'b1;
    end
    chk("timeout_seen", found, 1);
    chk("timeout_window", (cnt >= TMO - 2 && cnt <= TMO + 3), 1);
    @(negedge clk);
    chk("timeout_code", err_code, 3);
    chk("timeout_busy", busy, 0);
    idle(2);

    // Reset in the middle of PAYLOAD.
    send_byte(8'hA5, 1, 2); send_byte(8'h20, 1, 2); send_byte(8'h04, 1, 2);
    send_byte(8'hAA, 1, 2); send_byte(8'hBB, 1, 2);
    chk("pre_reset_busy", busy, 1);
    RSTn = 1'b0;
    #1 chk("midreset_outputs", {11'd0, wr_en, wr_addr, wr_data, pkt_ok, pkt_err, err_code, busy}, 0);
    cur.delete(); last_err = 2'd0;
    idle(3);
    RSTn = 1'b1;
    idle(30);
    chk("post_reset_busy", busy, 0);

    // rx_irq held high for 10 cycles counts once.
    send_byte(8'hA5, 10, 2); send_byte(8'h30, 1, 2); send_byte(8'h02, 10, 2);
    send_byte(8'h5A, 10, 2); send_byte(8'hA5, 1, 2);
    send_byte(8'h30 ^ 8'h02 ^ 8'h5A ^ 8'hA5, 10, 2);
    idle(10);

    // SYNC during DRAIN is replayed after pkt_ok.
    send_byte(8'hA5, 1, 1); send_byte(8'h50, 1, 1); send_byte(8'h04, 1, 1);
    x = 8'h50 ^ 8'h04;
    for (int i = 1; i <= 4; i++) begin send_byte(8'(i), 1, 1); x ^= 8'(i); end
    send_byte(x, 1, 1);
    send_byte(8'hA5, 1, 0);
    found = 1'b0; cnt = 0;
    while (!found && cnt < 40) begin
      @(negedge clk); cnt++;
      if (pkt_ok) found = 1'b1;
    end
    chk("pend_ok_seen", found, 1);
    @(negedge clk) chk("pend_busy_addr", busy, 1);
    send_byte(8'h60, 1, 2); send_byte(8'h01, 1, 2); send_byte(8'h77, 1, 2);
    send_byte(8'h60 ^ 8'h01 ^ 8'h77, 1, 2);
    idle(10);

    // Randomized traffic.
    for (int p = 0; p < 30; p++) begin
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h3C;
        send_byte(b, $urandom_range(1, 3), $urandom_range(1, 5));
      end
      addr = 8'($urandom_range(0, 255));
      len  = 8'($urandom_range(0, 18));
      send_byte(8'hA5, $urandom_range(1, 3), $urandom_range(1, 5));
      send_byte(addr, $urandom_range(1, 3), $urandom_range(1, 5));
      send_byte(len, $urandom_range(1, 3), $urandom_range(1, 5));
      if (len != 0 && len <= MAXL) begin
        x = addr ^ len;
        for (int i = 0; i < int'(len); i++) begin
          b = 8'($urandom_range(0, 255));
          x ^= b;
          send_byte(b, $urandom_range(1, 3), $urandom_range(1, 5));
        end
        if ($urandom_range(0, 4) == 0) x ^= 8'h5A;
        send_byte(x, $urandom_range(1, 3), $urandom_range(1, 5));
      end
      idle(25);
      chk("rand_err_code", err_code, last_err);
    end

    idle(40);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
